// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg
// Shared types and constants for the VGA framebuffer arbiter.
//   owner_e     : which requester owns a memory cycle (none, display, CPU)
//   FB_ADDR_W   : default framebuffer word-address width
//   FB_DATA_W   : default framebuffer data width
//   FB_WAIT_W   : width of the CPU starvation counter (MAX_WAIT is 1..15)
package vga_fb_pkg;

    localparam int FB_ADDR_W = 16;
    localparam int FB_DATA_W = 8;
    localparam int FB_WAIT_W = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DISP = 2'd1,
        OWN_CPU  = 2'd2
    } owner_e;

endpackage

// File: rtl/vga_fb_starve_ctr.sv
// vga_fb_starve_ctr
// Counts how many consecutive cycles the CPU has been requesting without
// being granted. Once the count reaches MAX_WAIT the CPU is flagged as
// starved so the arbiter lets it win over the display.
// Only instantiated when FB_ARB_STARVE_GUARD_EN is defined.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   cpu_req    : CPU request (held until granted)
//   cpu_gnt    : CPU grant from the arbiter this cycle
//   starved    : CPU has waited MAX_WAIT cycles and is still requesting
module vga_fb_starve_ctr
    import vga_fb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic cpu_req,
    input  logic cpu_gnt,
    output logic starved
);

    localparam logic [FB_WAIT_W-1:0] MAX_CNT = FB_WAIT_W'(MAX_WAIT);

    logic [FB_WAIT_W-1:0] wait_cnt_q;
    logic [FB_WAIT_W-1:0] wait_cnt_d;

    // Clear whenever the CPU stops asking or gets in; otherwise count up
    // and stick at the limit until the CPU is served.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!cpu_req || cpu_gnt) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != MAX_CNT) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Depends only on the registered count, so the grant path has no loop.
    assign starved = cpu_req && (wait_cnt_q == MAX_CNT);

endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
// Arbitrates a single-port framebuffer RAM between the display fetch and
// the CPU. Display wins ties; with FB_ARB_STARVE_GUARD_EN defined the CPU
// wins once it has waited MAX_WAIT cycles.
// Timing: request accepted at edge N (req && gnt), RAM command registered
// in cycle N+1, read data returned with rvalid in cycle N+2.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   disp_req/disp_addr                : display read request
//   disp_gnt/disp_rvalid/disp_rdata   : display grant and read return
//   cpu_req/cpu_we/cpu_addr/cpu_wdata : CPU read/write request
//   cpu_gnt/cpu_rvalid/cpu_rdata      : CPU grant and read return
//   mem_en/mem_we/mem_addr/mem_wdata  : RAM command (registered)
//   mem_rdata                         : RAM read data, one cycle after mem_en
// Configuration macro: FB_ARB_STARVE_GUARD_EN (CPU starvation guard).
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int ADDR_W   = FB_ADDR_W,
    parameter int DATA_W   = FB_DATA_W,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // state_q    : owner of the RAM command currently on the mem_* pins
    // rd_owner_q : owner of the read data arriving on mem_rdata this cycle
    owner_e            state_q, state_d;
    owner_e            rd_owner_q, rd_owner_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] disp_rdata_q, disp_rdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              starved;

`ifdef FB_ARB_STARVE_GUARD_EN
    vga_fb_starve_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_ctr (
        .clk     (clk),
        .rst     (rst),
        .cpu_req (cpu_req),
        .cpu_gnt (cpu_gnt),
        .starved (starved)
    );
`else
    assign starved = 1'b0;
`endif

    // Grants are purely combinational; nothing is granted while in reset.
    always_comb begin
        disp_gnt = 1'b0;
        cpu_gnt  = 1'b0;
        if (!rst) begin
            if (cpu_req && (starved || !disp_req)) begin
                cpu_gnt = 1'b1;
            end else if (disp_req) begin
                disp_gnt = 1'b1;
            end
        end
    end

    // Next owner and RAM command come from this cycle's accept. Address and
    // write data keep their old value when idle to avoid needless toggling.
    always_comb begin
        state_d     = OWN_NONE;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (disp_gnt) begin
            state_d    = OWN_DISP;
            mem_addr_d = disp_addr;
        end else if (cpu_gnt) begin
            state_d     = OWN_CPU;
            mem_we_d    = cpu_we;
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
        end
    end

    // Writes produce no return data, so they drop out of the read pipe.
    // Each port's rdata register follows the RAM only when it owns the data.
    always_comb begin
        rd_owner_d   = state_q;
        disp_rdata_d = disp_rdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        if (state_q == OWN_CPU && mem_we_q) begin
            rd_owner_d = OWN_NONE;
        end
        if (rd_owner_q == OWN_DISP) begin
            disp_rdata_d = mem_rdata;
        end
        if (rd_owner_q == OWN_CPU) begin
            cpu_rdata_d = mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= OWN_NONE;
            rd_owner_q   <= OWN_NONE;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            disp_rdata_q <= '0;
            cpu_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            rd_owner_q   <= rd_owner_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            disp_rdata_q <= disp_rdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
        end
    end

    // Outputs are forced quiet while rst is high, so a reset landing on an
    // in-flight access neither reaches the RAM nor returns data.
    assign mem_en      = !rst && (state_q != OWN_NONE);
    assign mem_we      = !rst && mem_we_q;
    assign mem_addr    = rst ? '0 : mem_addr_q;
    assign mem_wdata   = rst ? '0 : mem_wdata_q;
    assign disp_rvalid = !rst && (rd_owner_q == OWN_DISP);
    assign cpu_rvalid  = !rst && (rd_owner_q == OWN_CPU);
    assign disp_rdata  = rst ? '0 : disp_rdata_d;
    assign cpu_rdata   = rst ? '0 : cpu_rdata_d;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter
// Directed bench for vga_fb_arbiter with a behavioural RAM and a negedge
// monitor that predicts grants, RAM commands and read returns every cycle.
// Honours FB_ARB_STARVE_GUARD_EN for the starvation scenario.
module tb_vga_fb_arbiter;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 8;
    localparam int MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_gnt;
    logic              disp_rvalid;
    logic [DATA_W-1:0] disp_rdata;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [DATA_W-1:0] ram    [0:65535];
    logic [DATA_W-1:0] shadow [0:65535];

    int checkCount = 0;
    int passCount  = 0;

    vga_fb_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .disp_req    (disp_req),
        .disp_addr   (disp_addr),
        .disp_gnt    (disp_gnt),
        .disp_rvalid (disp_rvalid),
        .disp_rdata  (disp_rdata),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_gnt     (cpu_gnt),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM with one cycle of read latency
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic dreq, input logic [ADDR_W-1:0] daddr,
                                 input logic creq, input logic cwe,
                                 input logic [ADDR_W-1:0] caddr,
                                 input logic [DATA_W-1:0] cwdata);
        disp_req  = dreq;
        disp_addr = daddr;
        cpu_req   = creq;
        cpu_we    = cwe;
        cpu_addr  = caddr;
        cpu_wdata = cwdata;
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    // Cycle monitor: predicts grants with its own priority/starvation model,
    // then the RAM command one cycle after each accept and the read return
    // two cycles after, with expected data from a shadow copy of the RAM.
    logic              p1V, p1We, p1Cpu, p2V, p2Cpu;
    logic [ADDR_W-1:0] p1Addr;
    logic [DATA_W-1:0] p1Wdata, p1Data, p2Data, lastDisp, lastCpu;
    int                waitCnt;
    logic              expDg, expCg, starvedM;

    always @(negedge clk) begin
        if (rst) begin
            checkOutput("rst_ctrl", {disp_gnt, cpu_gnt, disp_rvalid, cpu_rvalid, mem_en, mem_we}, 64'h0);
            checkOutput("rst_data", {mem_addr, mem_wdata, disp_rdata, cpu_rdata}, 64'h0);
            p1V = 0; p2V = 0; p1We = 0; p1Cpu = 0; p2Cpu = 0;
            lastDisp = '0; lastCpu = '0; waitCnt = 0;
        end else begin
`ifdef FB_ARB_STARVE_GUARD_EN
            starvedM = cpu_req && (waitCnt == MAX_WAIT);
`else
            starvedM = 1'b0;
`endif
            expDg = disp_req && !starvedM;
            expCg = cpu_req && (!disp_req || starvedM);
            checkOutput("gnt_disp", disp_gnt, expDg);
            checkOutput("gnt_cpu", cpu_gnt, expCg);
            checkOutput("one_gnt", disp_gnt & cpu_gnt, 0);

            checkOutput("mem_en", mem_en, p1V);
            if (p1V) begin
                checkOutput("mem_we", mem_we, p1We);
                checkOutput("mem_addr", mem_addr, p1Addr);
                if (p1We) checkOutput("mem_wdata", mem_wdata, p1Wdata);
            end

            checkOutput("disp_rvalid", disp_rvalid, p2V && !p2Cpu);
            checkOutput("cpu_rvalid", cpu_rvalid, p2V && p2Cpu);
            if (p2V && !p2Cpu) lastDisp = p2Data;
            if (p2V && p2Cpu)  lastCpu  = p2Data;
            checkOutput("disp_rdata", disp_rdata, lastDisp);
            checkOutput("cpu_rdata", cpu_rdata, lastCpu);

            p2V    = p1V && !p1We;
            p2Cpu  = p1Cpu;
            p2Data = p1Data;
            p1V    = expDg || expCg;
            p1Cpu  = expCg;
            p1We   = expCg && cpu_we;
            p1Addr = expCg ? cpu_addr : disp_addr;
            p1Wdata = cpu_wdata;
            if (p1We) shadow[p1Addr] = cpu_wdata;
            p1Data = shadow[p1Addr];

            if (!cpu_req || expCg)      waitCnt = 0;
            else if (waitCnt < MAX_WAIT) waitCnt++;
        end
    end

    logic [ADDR_W-1:0] altAddr [4];
    logic [DATA_W-1:0] altData [4];
    int  firstCpu, dispCount;
    logic dPend, cPend;

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram[i]    = 8'(i) ^ 8'h5A;
            shadow[i] = 8'(i) ^ 8'h5A;
        end
        ram[16'h0010]    = 8'hA5;
        shadow[16'h0010] = 8'hA5;
        mem_rdata = '0;
        rst = 1'b1;
        // Requests held during reset must not be granted
        applyStimulus(1, 16'h0010, 1, 0, 16'h0000, 8'h00);
        repeat (3) begin
            @(negedge clk);
            checkOutput("rst_no_gnt", {disp_gnt, cpu_gnt}, 0);
        end

        // Display read of 0x0010 holding 0xA5
        waitCycle();
        rst = 1'b0;
        applyStimulus(1, 16'h0010, 0, 0, 16'h0000, 8'h00);
        @(negedge clk); checkOutput("d_gnt", disp_gnt, 1);
        waitCycle();
        applyStimulus(0, 16'h0000, 0, 0, 16'h0000, 8'h00);
        @(negedge clk);
        checkOutput("d_mem_cmd", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 16'h0010});
        @(negedge clk);
        checkOutput("d_ret", {disp_rvalid, disp_rdata}, {1'b1, 8'hA5});
        @(negedge clk);
        checkOutput("d_hold", {disp_rvalid, disp_rdata}, {1'b0, 8'hA5});

        // CPU write 0x3C to 0x0200, then display reads it back
        waitCycle();
        applyStimulus(0, 16'h0000, 1, 1, 16'h0200, 8'h3C);
        @(negedge clk); checkOutput("c_wr_gnt", cpu_gnt, 1);
        waitCycle();
        applyStimulus(0, 16'h0000, 0, 0, 16'h0000, 8'h00);
        @(negedge clk);
        checkOutput("c_wr_cmd", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 16'h0200, 8'h3C});
        @(negedge clk); checkOutput("c_wr_no_rvalid", cpu_rvalid, 0);
        waitCycle();
        applyStimulus(1, 16'h0200, 0, 0, 16'h0000, 8'h00);
        @(negedge clk); checkOutput("rb_gnt", disp_gnt, 1);
        waitCycle();
        applyStimulus(0, 16'h0000, 0, 0, 16'h0000, 8'h00);
        @(negedge clk);
        @(negedge clk);
        checkOutput("rb_ret", {disp_rvalid, disp_rdata}, {1'b1, 8'h3C});

        // Both requesting continuously
        waitCycle();
        applyStimulus(1, 16'h0300, 1, 0, 16'h0301, 8'h00);
        firstCpu = 0;
        dispCount = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (cpu_gnt) begin
                firstCpu = i;
                break;
            end
            if (disp_gnt) dispCount++;
            waitCycle();
        end
`ifdef FB_ARB_STARVE_GUARD_EN
        checkOutput("starve_cpu_cycle", firstCpu, 5);
        checkOutput("starve_disp_cnt", dispCount, 4);
        waitCycle();
        @(negedge clk); checkOutput("starve_cleared", disp_gnt, 1);
        waitCycle();
`else
        checkOutput("strict_no_cpu", firstCpu, 0);
        checkOutput("strict_disp_cnt", dispCount, 12);
`endif
        applyStimulus(0, 16'h0000, 1, 0, 16'h0301, 8'h00);
        @(negedge clk); checkOutput("cpu_only_gnt", cpu_gnt, 1);
        waitCycle();
        applyStimulus(0, 16'h0000, 0, 0, 16'h0000, 8'h00);
        repeat (3) waitCycle();

        // Alternating D, C, D, C reads, one accept per cycle
        altAddr[0] = 16'h0400; altData[0] = 8'h5A;
        altAddr[1] = 16'h0401; altData[1] = 8'h5B;
        altAddr[2] = 16'h0402; altData[2] = 8'h58;
        altAddr[3] = 16'h0403; altData[3] = 8'h59;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                if (k % 2 == 0) applyStimulus(1, altAddr[k], 0, 0, 16'h0000, 8'h00);
                else            applyStimulus(0, 16'h0000, 1, 0, altAddr[k], 8'h00);
            end else begin
                applyStimulus(0, 16'h0000, 0, 0, 16'h0000, 8'h00);
            end
            @(negedge clk);
            if (k < 4) checkOutput("alt_gnt", {disp_gnt, cpu_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01);
            if (k >= 2) begin
                if ((k - 2) % 2 == 0)
                    checkOutput("alt_d_ret", {disp_rvalid, cpu_rvalid, disp_rdata}, {2'b10, altData[k-2]});
                else
                    checkOutput("alt_c_ret", {disp_rvalid, cpu_rvalid, cpu_rdata}, {2'b01, altData[k-2]});
            end
            waitCycle();
        end
        repeat (2) waitCycle();

        // Reset one cycle after a display read accept
        applyStimulus(1, 16'h0010, 0, 0, 16'h0000, 8'h00);
        @(negedge clk); checkOutput("rr_gnt", disp_gnt, 1);
        waitCycle();
        rst = 1'b1;
        applyStimulus(0, 16'h0000, 0, 0, 16'h0000, 8'h00);
        @(negedge clk); checkOutput("rr_in_rst", {disp_rvalid, mem_en, disp_rdata}, 0);
        waitCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rr_after", {disp_rvalid, cpu_rvalid, mem_en, mem_we, mem_addr, disp_rdata}, 0);
        @(negedge clk); checkOutput("rr_after2", {disp_rvalid, cpu_rvalid}, 0);

        // Random stress on a small address window to provoke hazards
        waitCycle();
        dPend = 0;
        cPend = 0;
        for (int n = 0; n < 400; n++) begin
            if (!dPend && ($urandom_range(0, 1) == 1)) begin
                dPend     = 1;
                disp_addr = 16'h0500 + 16'($urandom_range(0, 15));
            end
            if (!cPend && ($urandom_range(0, 2) != 0)) begin
                cPend     = 1;
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = 16'h0500 + 16'($urandom_range(0, 15));
                cpu_wdata = 8'($urandom_range(0, 255));
            end
            disp_req = dPend;
            cpu_req  = cPend;
            @(negedge clk);
            if (disp_req && disp_gnt) dPend = 0;
            if (cpu_req && cpu_gnt)   cPend = 0;
            waitCycle();
        end
        applyStimulus(0, 16'h0000, 0, 0, 16'h0000, 8'h00);
        repeat (4) waitCycle();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, framebuffer word-address width SHALL be supported.
REQ-002 Parameter DATA_W, default 8, framebuffer data width SHALL be supported.
REQ-003 Parameter MAX_WAIT, default 4, SHALL set the CPU starvation limit in cycles (range 1..15).
REQ-004 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 disp_req in 1 / disp_addr in ADDR_W: display fetch read request, held until granted.
REQ-007 disp_gnt out 1 / disp_rvalid out 1 / disp_rdata out DATA_W: display grant and read return.
REQ-008 cpu_req in 1 / cpu_we in 1 / cpu_addr in ADDR_W / cpu_wdata in DATA_W: CPU request, held until granted.
REQ-009 cpu_gnt out 1 / cpu_rvalid out 1 / cpu_rdata out DATA_W: CPU grant and read return.
REQ-010 mem_en out 1 / mem_we out 1 / mem_addr out ADDR_W / mem_wdata out DATA_W / mem_rdata in DATA_W: single-port RAM; one-cycle read latency.

Function
REQ-011 Grants SHALL be combinational from current req and state; at most one gnt high per cycle.
REQ-012 A request SHALL be accepted at the rising edge where req and gnt are both high; requester may change req/addr after that edge.
REQ-013 Accepted access SHALL drive registered mem_en=1, mem_addr, mem_we (0 for display, cpu_we for CPU), mem_wdata in the cycle after acceptance.
REQ-014 Read data SHALL return with rvalid=1 on the owner's port exactly 2 cycles after acceptance; rdata SHALL equal mem_rdata registered-through.
REQ-015 CPU writes SHALL NOT assert cpu_rvalid.
REQ-016 Back-to-back accepts every cycle SHALL be supported, any mix of owners.
REQ-017 Owner pipeline FSM states: IDLE, DISP, CPU = owner of the mem cycle in flight; next state = owner of this cycle's accept, IDLE if none.
REQ-018 Both req high: display SHALL win, except per REQ-021.
REQ-019 Only one req high: that requester SHALL be granted that cycle.
REQ-020 Non-granted rdata outputs SHALL hold their last value.

Configuration
REQ-021 With FB_ARB_STARVE_GUARD_EN defined: wait counter SHALL increment each cycle cpu_req=1 and cpu_gnt=0, saturating at MAX_WAIT; when counter == MAX_WAIT and cpu_req=1, CPU SHALL win over display; counter SHALL clear on CPU accept or when cpu_req=0.
REQ-022 Without FB_ARB_STARVE_GUARD_EN: strict display priority; no counter logic SHALL exist.

Reset
REQ-023 While rst=1: all gnt, rvalid, mem_en, mem_we SHALL be 0; mem_addr, mem_wdata, rdata outputs 0; FSM IDLE; counter 0.
REQ-024 Reset during an in-flight read SHALL suppress that read's rvalid; no rvalid SHALL occur in the first 2 cycles after rst deasserts unless newly accepted.
REQ-025 No grant SHALL be issued in a cycle where rst=1.

Structure
REQ-026 Package vga_fb_pkg SHALL hold owner enum (OWN_NONE, OWN_DISP, OWN_CPU) and default ADDR_W/DATA_W constants.
REQ-027 Starvation counter SHALL be sub-module vga_fb_starve_ctr, instantiated only under FB_ARB_STARVE_GUARD_EN.

Verification
REQ-028 Display only, disp_addr=0x0010 accepted cycle N, RAM holds 0xA5 -> mem_en=1/mem_we=0/mem_addr=0x0010 in N+1, disp_rvalid=1 disp_rdata=0xA5 in N+2.
REQ-029 CPU write cpu_addr=0x0200 cpu_wdata=0x3C -> mem_we=1 mem_wdata=0x3C cycle after accept; cpu_rvalid never asserted; later display read of 0x0200 returns 0x3C.
REQ-030 Both req held continuously, MAX_WAIT=4, guard enabled -> 4 display grants, then cpu_gnt on 5th cycle, counter cleared; guard disabled -> cpu_gnt never while disp_req=1.
REQ-031 Alternating accepts D,C,D,C (CPU reads) -> rvalid on matching port 2 cycles after each accept, data never misrouted.
REQ-032 rst asserted one cycle after a display read accept -> no disp_rvalid; all outputs 0 next cycle.
REQ-033 Random req/addr stress vs RAM reference model -> at most one gnt per cycle; all reads match model.
